// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH working register file for the ALU datapath.
// One operation per cycle on the entry at waddr. Two combinational read
// ports and a registered carry/shift-out flag (cout).
// Optional build macro: REG_BANK_BYPASS_EN adds write-through bypass on
// both read ports.
// Interface timing: there is no handshake. A new op is accepted on every
// rising edge, and a result is visible on the read ports after that edge.
module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             sin,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             cout
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_cout;
  logic             wr_en;
  logic             flag_en;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // Next-state value of the addressed entry and of the flag.
  always_comb begin
    wr_en    = (op != OP_NOP) && in_range(waddr);
    flag_en  = 1'b0;
    cur      = in_range(waddr) ? regs[waddr] : '0;
    nxt      = cur;
    nxt_cout = cout;
    case (op)
      OP_LOAD: nxt = wdata;
      OP_CLR:  nxt = '0;
      OP_SHL: begin
        nxt      = {cur[WIDTH-2:0], sin};
        nxt_cout = cur[WIDTH-1];
        flag_en  = 1'b1;
      end
      OP_SHR: begin
        nxt      = {sin, cur[WIDTH-1:1]};
        nxt_cout = cur[0];
        flag_en  = 1'b1;
      end
      OP_ROL: begin
        nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
        nxt_cout = cur[WIDTH-1];
        flag_en  = 1'b1;
      end
      OP_INC: begin
        nxt      = cur + WIDTH'(1);
        nxt_cout = &cur;
        flag_en  = 1'b1;
      end
      OP_DEC: begin
        nxt      = cur - WIDTH'(1);
        nxt_cout = ~|cur;
        flag_en  = 1'b1;
      end
      default: begin
        nxt      = cur;
        nxt_cout = cout;
      end
    endcase
    // An out-of-range target is a NOP, so the flag must hold as well.
    flag_en = flag_en && in_range(waddr);
  end

  // Storage and flag update; reset discards the op of the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      cout <= 1'b0;
    end else begin
      if (wr_en) regs[waddr] <= nxt;
      if (flag_en) cout <= nxt_cout;
    end
  end

  // Stored contents seen by each read port; out-of-range reads give 0.
  always_comb begin
    stored_a = in_range(raddr_a) ? regs[raddr_a] : '0;
    stored_b = in_range(raddr_b) ? regs[raddr_b] : '0;
  end

`ifdef REG_BANK_BYPASS_EN
  // Write-through: a port aimed at the entry being written shows its next value.
  always_comb begin
    if (rst) begin
      rdata_a = '0;
      rdata_b = '0;
    end else begin
      rdata_a = (wr_en && (waddr == raddr_a)) ? nxt : stored_a;
      rdata_b = (wr_en && (waddr == raddr_b)) ? nxt : stored_b;
    end
  end
`else
  // Read ports always show stored contents.
  always_comb begin
    rdata_a = stored_a;
    rdata_b = stored_b;
  end
`endif

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed test plan, out-of-range checks on a DEPTH=6 bank,
// and a randomized phase against an arithmetic reference model.
module tb_reg_bank;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [2:0]   waddr = 3'd0;
  logic [W-1:0] wdata = '0;
  logic         sin = 1'b0;
  logic [2:0]   raddr_a = 3'd0;
  logic [2:0]   raddr_b = 3'd0;
  logic [W-1:0] rdata_a;
  logic [W-1:0] rdata_b;
  logic         cout;

  logic         rst6 = 1'b1;
  logic [2:0]   op6 = 3'd0;
  logic [2:0]   waddr6 = 3'd0;
  logic [W-1:0] wdata6 = '0;
  logic         sin6 = 1'b0;
  logic [2:0]   raddr6_a = 3'd0;
  logic [2:0]   raddr6_b = 3'd0;
  logic [W-1:0] rdata6_a;
  logic [W-1:0] rdata6_b;
  logic         cout6;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: register contents and flag
  int mdl [8];
  int mcout;

  reg_bank #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .op(op), .waddr(waddr), .wdata(wdata), .sin(sin),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .cout(cout)
  );

  reg_bank #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst6), .op(op6), .waddr(waddr6), .wdata(wdata6), .sin(sin6),
    .raddr_a(raddr6_a), .raddr_b(raddr6_b), .rdata_a(rdata6_a), .rdata_b(rdata6_b),
    .cout(cout6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Spec rules in plain arithmetic on 0..255 integers.
  task automatic model_next(input int o, input int r, input int wd, input int s,
                            input int c, output int nv, output int nc);
    nv = r;
    nc = c;
    case (o)
      1: nv = wd;
      2: nv = 0;
      3: begin nv = (r * 2 + s) % 256; nc = r / 128; end
      4: begin nv = r / 2 + s * 128;   nc = r % 2;   end
      5: begin nv = (r * 2) % 256 + r / 128; nc = r / 128; end
      6: begin nv = (r + 1) % 256;     nc = (r == 255) ? 1 : 0; end
      7: begin nv = (r + 255) % 256;   nc = (r == 0) ? 1 : 0; end
      default: ;
    endcase
  endtask

  // One op cycle: drive at negedge, check reads/flag before the edge, update model.
  task automatic step(input int o, input int wa, input int wd, input int s,
                      input int ra, input int rb);
    int nv, nc, ea, eb;
    @(negedge clk);
    rst = 1'b0; op = o[2:0]; waddr = wa[2:0]; wdata = wd[7:0]; sin = s[0];
    raddr_a = ra[2:0]; raddr_b = rb[2:0];
    model_next(o, mdl[wa], wd, s, mcout, nv, nc);
    ea = mdl[ra];
    eb = mdl[rb];
`ifdef REG_BANK_BYPASS_EN
    if (o != 0 && wa == ra) ea = nv;
    if (o != 0 && wa == rb) eb = nv;
`endif
    #1;
    chk("rdata_a", rdata_a, ea[7:0]);
    chk("rdata_b", rdata_b, eb[7:0]);
    chk("cout", {7'd0, cout}, mcout[7:0]);
    @(posedge clk);
    mdl[wa] = nv;
    mcout = nc;
  endtask

  // Reset cycle carrying an op that must be discarded.
  task automatic rst_step(input int o, input int wa, input int wd);
    int ea;
    @(negedge clk);
    rst = 1'b1; op = o[2:0]; waddr = wa[2:0]; wdata = wd[7:0];
    ea = mdl[raddr_a];
`ifdef REG_BANK_BYPASS_EN
    ea = 0;
`endif
    #1;
    chk("rdata_a_in_rst", rdata_a, ea[7:0]);
    @(posedge clk);
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    mcout = 0;
  endtask

  // NOP cycle reading r, then checks against spec constants after the edge.
  task automatic peek(input string tag, input int r, input int ev, input int ec);
    step(0, 0, 0, 0, r, r);
    #1;
    chk(tag, rdata_a, ev[7:0]);
    chk({tag, "_cout"}, {7'd0, cout}, ec[7:0]);
  endtask

  task automatic step6(input int o, input int wa, input int wd, input int s);
    @(negedge clk);
    rst6 = 1'b0; op6 = o[2:0]; waddr6 = wa[2:0]; wdata6 = wd[7:0]; sin6 = s[0];
    @(posedge clk);
  endtask

  initial begin
    int ev;
    // initial reset of both banks
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    mcout = 0;
    @(negedge clk);
    rst = 1'b0;
    rst6 = 1'b0;

    // reset state
    peek("reset_r0", 0, 0, 0);
    peek("reset_r6", 6, 0, 0);

    // reset then LOAD
    step(1, 3, 8'hA5, 0, 0, 0);
    step(1, 5, 8'h3C, 0, 0, 0);
    step(0, 0, 0, 0, 3, 5);
    #1;
    chk("load_r3", rdata_a, 8'hA5);
    chk("load_r5", rdata_b, 8'h3C);
    chk("load_cout", {7'd0, cout}, 8'h00);

    // shifts and rotate on r2
    step(1, 2, 8'h81, 0, 2, 2);
    step(3, 2, 0, 0, 2, 2);
    peek("shl_r2", 2, 8'h02, 1);
    step(4, 2, 0, 1, 2, 2);
    peek("shr_r2", 2, 8'h81, 0);
    step(5, 2, 0, 0, 2, 2);
    peek("rol_r2", 2, 8'h03, 1);

    // increment/decrement wrap on r7
    step(1, 7, 8'hFF, 0, 7, 7);
    step(6, 7, 0, 0, 7, 7);
    peek("inc_wrap", 7, 8'h00, 1);
    step(7, 7, 0, 0, 7, 7);
    peek("dec_wrap", 7, 8'hFF, 1);
    step(7, 7, 0, 0, 7, 7);
    peek("dec_nowrap", 7, 8'hFE, 0);

    // back-to-back INC chains
    step(6, 7, 0, 0, 0, 0);
    step(6, 7, 0, 0, 0, 0);
    peek("inc_inc", 7, 8'h00, 1);

    // read-during-write on r1
    step(1, 1, 8'h10, 0, 1, 1);
    @(negedge clk);
    op = 3'd1; waddr = 3'd1; wdata = 8'h55; raddr_a = 3'd1;
    #1;
`ifdef REG_BANK_BYPASS_EN
    chk("rdw_same_cycle", rdata_a, 8'h55);
`else
    chk("rdw_same_cycle", rdata_a, 8'h10);
`endif
    @(posedge clk);
    mdl[1] = 8'h55;
    #1;
    chk("rdw_after", rdata_a, 8'h55);

    // mid-stream reset on r4 with the flag set first
    step(1, 4, 8'hFD, 0, 4, 4);
    step(6, 4, 0, 0, 4, 4);
    step(6, 4, 0, 0, 4, 4);
    step(6, 4, 0, 0, 4, 4);
    rst_step(1, 4, 8'hFF);
    peek("midrst_r4", 4, 0, 0);

    // randomized phase with occasional reset
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 40) == 0)
        rst_step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
      else
        step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    @(negedge clk);
    op = 3'd0;
    rst = 1'b0;

    // out-of-range addresses on the DEPTH=6 bank
    for (int i = 0; i < 6; i++) step6(1, i, 17 * (i + 1), 0);
    step6(1, 0, 8'hFF, 0);
    step6(6, 0, 0, 0);
    step6(1, 7, 8'hEE, 0);
    step6(4, 6, 0, 0);
    step6(7, 7, 0, 0);
    @(negedge clk);
    op6 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raddr6_a = i[2:0];
      #1;
      ev = (i == 0) ? 0 : 17 * (i + 1);
      chk("oor_hold", rdata6_a, ev[7:0]);
    end
    raddr6_b = 3'd6;
    #1;
    chk("oor_read6", rdata6_b, 8'h00);
    raddr6_b = 3'd7;
    #1;
    chk("oor_read7", rdata6_b, 8'h00);
    chk("oor_cout", {7'd0, cout6}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of `DEPTH` registers, each `WIDTH` bits wide, for the ALU datapath. It is the multi-entry successor to the plain clocked register. Each cycle it applies one operation to one addressed entry: load, clear, shift, rotate, increment or decrement. It provides two independent read ports and a registered carry/shift-out flag. It sits between the ALU result bus and the ALU operand inputs, and acts as the datapath's working register file.

## Interface
- `WIDTH`, default 8: bits per register; must be at least 2.
- `DEPTH`, default 8: number of registers; must be at least 2.
- `AW`, default `$clog2(DEPTH)`: address width; derived, not overridden.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 3: operation code.
  - 000 NOP, 001 LOAD, 010 CLR, 011 SHL
  - 100 SHR, 101 ROL, 110 INC, 111 DEC
- `waddr` in AW: target register for `op`.
- `wdata` in WIDTH: load value, used by LOAD only.
- `sin` in 1: serial input bit for SHL (enters bit 0) and SHR (enters bit WIDTH-1).
- `raddr_a` in AW: read port A address.
- `raddr_b` in AW: read port B address.
- `rdata_a` out WIDTH: contents of register `raddr_a`.
- `rdata_b` out WIDTH: contents of register `raddr_b`.
- `cout` out 1: registered carry, borrow or shifted-out bit of the last flag-producing op.

## Operation
- Reset: when `rst`=1 at a rising edge, all registers and `cout` are cleared to 0, and `op` is ignored that cycle.
  - After reset, both read ports return 0.
- Register update at the rising edge, with R = reg[`waddr`]:
  - LOAD: R <= `wdata`.
  - CLR: R <= 0.
  - SHL: R <= {R[WIDTH-2:0], `sin`}; `cout` <= R[WIDTH-1].
  - SHR: R <= {`sin`, R[WIDTH-1:1]}; `cout` <= R[0].
  - ROL: R <= {R[WIDTH-2:0], R[WIDTH-1]}; `cout` <= R[WIDTH-1].
  - INC: R <= R+1, mod 2^WIDTH; `cout` <= 1 only on the wrap from all-ones to 0.
  - DEC: R <= R-1, mod 2^WIDTH; `cout` <= 1 (borrow) only on the wrap from 0 to all-ones.
- `cout` holds its value on NOP, LOAD and CLR.
- Only the addressed register changes; all other registers hold.
- Read ports are combinational from stored state. Both ports may address the same register, or the register being written.
- Out-of-range addresses, possible only when DEPTH is not a power of two:
  - An op with an out-of-range `waddr` is a NOP, and `cout` holds.
  - A read with an out-of-range address returns 0.

## Timing
- Write latency is 1 cycle: the result of an op sampled at edge N is visible on the read ports after edge N.
- Read-during-write to the same address, without bypass: the port returns the old value until the edge.
- No handshake: a new op is accepted every cycle, and back-to-back ops on the same register chain correctly. For example, INC followed by INC gives +2.
- Reset asserted mid-sequence discards the op in that cycle. The next cycle starts from the all-zero state.

## Configuration
- `REG_BANK_BYPASS_EN` defined: write-through bypass on both read ports.
  - When `op`≠NOP, `waddr` is in range and equals `raddr_x`, `rdata_x` shows the value being written this cycle (the next-state value), combinationally.
  - During `rst`=1, both read ports return 0.
- `REG_BANK_BYPASS_EN` not defined: read ports always show stored contents.
- `cout` behaviour is identical in both builds.

## Test plan
- Reset, then LOAD: reset, then LOAD 0xA5 to r3 and LOAD 0x3C to r5; set `raddr_a`=3, `raddr_b`=5.
  - Required: `rdata_a`=0xA5, `rdata_b`=0x3C, `cout`=0.
- Shifts and rotate on r2: r2=0x81.
  - SHL with `sin`=0 → r2=0x02, `cout`=1.
  - SHR with `sin`=1 → r2=0x81, `cout`=0.
  - ROL → r2=0x03, `cout`=1.
- Increment and decrement wrap on r7:
  - r7=0xFF, INC → r7=0x00, `cout`=1.
  - DEC → r7=0xFF, `cout`=1.
  - DEC → r7=0xFE, `cout`=0.
- Read-during-write: LOAD 0x55 to r1 while `raddr_a`=1 and the old r1 value is 0x10.
  - Without the macro: `rdata_a`=0x10 in that cycle, then 0x55.
  - With `REG_BANK_BYPASS_EN`: `rdata_a`=0x55 in the same cycle.
- Mid-stream reset: run INC on r4 for 3 cycles, then assert `rst` in the same cycle as LOAD 0xFF to r4.
  - Required: r4=0 and `cout`=0 afterwards; the LOAD is lost.
- Out-of-range address, with DEPTH=6:
  - LOAD to `waddr`=7 leaves all registers unchanged.
  - `raddr_b`=6 gives `rdata_b`=0.
